// File: rtl/dataflow_pkg.sv
// Shared definitions for the parametrised dataflow core: bus source encoding,
// width helpers and illegal-command flag positions.
package dataflow_pkg;

    localparam int SRC_IDLE = 0;
    localparam int SRC_GPR0 = 1;

    localparam int ILL_PC = 0;
    localparam int ILL_SP = 1;

    typedef enum logic [1:0] {
        SP_HOLD,
        SP_PUSH,
        SP_POP,
        SP_LOAD
    } spOp_e;

    // Non-GPR sources follow the GPR block in a fixed order.
    function automatic int srcPcl(input int numGpr);
        return SRC_GPR0 + numGpr;
    endfunction

    function automatic int srcPch(input int numGpr);
        return SRC_GPR0 + numGpr + 1;
    endfunction

    function automatic int srcSp(input int numGpr);
        return SRC_GPR0 + numGpr + 2;
    endfunction

    function automatic int srcDil(input int numGpr);
        return SRC_GPR0 + numGpr + 3;
    endfunction

    function automatic int srcConst(input int numGpr);
        return SRC_GPR0 + numGpr + 4;
    endfunction

    function automatic int srcWidth(input int numGpr);
        return $clog2(numGpr + 6);
    endfunction

    function automatic int busWidth(input int numBus);
        return (numBus > 1) ? $clog2(numBus) : 1;
    endfunction

endpackage

// File: rtl/dataflow_if.sv
// Control/select and result signals between the decoder, the dataflow core
// and the external memory interface.
interface dataflow_if
    import dataflow_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_GPR = 3,
    parameter int NUM_BUS = 3
);
    localparam int SRC_W = srcWidth(NUM_GPR);
    localparam int BUS_W = busWidth(NUM_BUS);

    logic [NUM_BUS*SRC_W-1:0]  bus_src_sel;
    logic [DATA_W-1:0]         const_in;
    logic [NUM_GPR-1:0]        gpr_load_en;
    logic [NUM_GPR*BUS_W-1:0]  gpr_load_bus;
    logic                      pc_inc;
    logic                      pc_dec;
    logic                      pc_load;
    logic [BUS_W-1:0]          pc_lo_bus;
    logic [BUS_W-1:0]          pc_hi_bus;
    logic                      sp_push;
    logic                      sp_pop;
    logic                      sp_load;
    logic [BUS_W-1:0]          sp_bus;
    logic                      abl_load;
    logic [BUS_W-1:0]          abl_bus;
    logic                      abh_load;
    logic [BUS_W-1:0]          abh_bus;
    logic                      dor_load;
    logic [BUS_W-1:0]          dor_bus;
    logic                      dil_load;
    logic [DATA_W-1:0]         ext_data_in;
    logic [DATA_W-1:0]         ext_data_out;
    logic [2*DATA_W-1:0]       addr_out;
    logic [2*DATA_W-1:0]       pc_out;
    logic [DATA_W-1:0]         sp_out;
    logic                      page_cross;
    logic [1:0]                illegal_cmd;
    logic [NUM_BUS*DATA_W-1:0] bus_mon;

    modport master (
        output bus_src_sel, const_in, gpr_load_en, gpr_load_bus,
               pc_inc, pc_dec, pc_load, pc_lo_bus, pc_hi_bus,
               sp_push, sp_pop, sp_load, sp_bus,
               abl_load, abl_bus, abh_load, abh_bus, dor_load, dor_bus,
               dil_load, ext_data_in,
        input  ext_data_out, addr_out, pc_out, sp_out, page_cross,
               illegal_cmd, bus_mon
    );

    modport slave (
        input  bus_src_sel, const_in, gpr_load_en, gpr_load_bus,
               pc_inc, pc_dec, pc_load, pc_lo_bus, pc_hi_bus,
               sp_push, sp_pop, sp_load, sp_bus,
               abl_load, abl_bus, abh_load, abh_bus, dor_load, dor_bus,
               dil_load, ext_data_in,
        output ext_data_out, addr_out, pc_out, sp_out, page_cross,
               illegal_cmd, bus_mon
    );

endinterface

// File: rtl/dataflow_bus_mux.sv
// One internal bus: encoded source select over the register file, PC, SP,
// DIL and the controller constant. Unused codes read the precharge value.
module dataflow_bus_mux
    import dataflow_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                NUM_GPR    = 3,
    parameter logic [DATA_W-1:0] IDLE_VALUE = '1,
    parameter int                SRC_W      = srcWidth(NUM_GPR)
) (
    input  logic [SRC_W-1:0]          srcSel,
    input  logic [NUM_GPR*DATA_W-1:0] gprFlat,
    input  logic [DATA_W-1:0]         pcLo,
    input  logic [DATA_W-1:0]         pcHi,
    input  logic [DATA_W-1:0]         spVal,
    input  logic [DATA_W-1:0]         dilVal,
    input  logic [DATA_W-1:0]         constVal,
    output logic [DATA_W-1:0]         busVal
);

    always_comb begin
        busVal = IDLE_VALUE;
        for (int g = 0; g < NUM_GPR; g++) begin
            if (srcSel == SRC_W'(SRC_GPR0 + g)) busVal = gprFlat[g*DATA_W +: DATA_W];
        end
        if (srcSel == SRC_W'(srcPcl(NUM_GPR)))   busVal = pcLo;
        if (srcSel == SRC_W'(srcPch(NUM_GPR)))   busVal = pcHi;
        if (srcSel == SRC_W'(srcSp(NUM_GPR)))    busVal = spVal;
        if (srcSel == SRC_W'(srcDil(NUM_GPR)))   busVal = dilVal;
        if (srcSel == SRC_W'(srcConst(NUM_GPR))) busVal = constVal;
    end

endmodule

// File: rtl/dataflow_core_param.sv
// Parametrised internal datapath: encoded-source buses feeding GPRs, PC, SP,
// address/data output registers and the data-input latch.
module dataflow_core_param
    import dataflow_pkg::*;
#(
    parameter int                  DATA_W     = 8,
    parameter int                  NUM_GPR    = 3,
    parameter int                  NUM_BUS    = 3,
    parameter logic [2*DATA_W-1:0] RESET_PC   = 16'hFFFC,
    parameter logic [DATA_W-1:0]   SP_RESET   = 8'hFF,
    parameter logic [DATA_W-1:0]   IDLE_VALUE = '1
) (
    input logic       clk,
    input logic       nrst,
    dataflow_if.slave ctl
);

    localparam int SRC_W  = srcWidth(NUM_GPR);
    localparam int BUS_W  = busWidth(NUM_BUS);
    localparam int ADDR_W = 2 * DATA_W;

    logic [DATA_W-1:0]         gpr [NUM_GPR];
    logic [NUM_GPR*DATA_W-1:0] gprFlat;
    logic [ADDR_W-1:0]         pc;
    logic [DATA_W-1:0]         sp;
    logic [DATA_W-1:0]         abl;
    logic [DATA_W-1:0]         abh;
    logic [DATA_W-1:0]         dor;
    logic [DATA_W-1:0]         dil;
    logic                      pageCross;
    logic [1:0]                illegalCmd;
    logic [NUM_BUS*DATA_W-1:0] busFlat;

    logic [ADDR_W-1:0] pcBase;
    logic [ADDR_W-1:0] pcNext;
    logic              pcStep;
    logic              pcConflict;
    logic              pcCross;
    logic              spConflict;
    spOp_e             spOp;

    // A bus index past the last bus behaves like an idle (precharged) bus.
    function automatic logic [DATA_W-1:0] pickBus(input logic [BUS_W-1:0] idx,
                                                  input logic [NUM_BUS*DATA_W-1:0] flat);
        pickBus = IDLE_VALUE;
        for (int b = 0; b < NUM_BUS; b++) begin
            if (idx == BUS_W'(b)) pickBus = flat[b*DATA_W +: DATA_W];
        end
    endfunction

    always_comb begin
        gprFlat = '0;
        for (int g = 0; g < NUM_GPR; g++) gprFlat[g*DATA_W +: DATA_W] = gpr[g];
    end

    for (genvar b = 0; b < NUM_BUS; b++) begin : gBus
        dataflow_bus_mux #(
            .DATA_W     (DATA_W),
            .NUM_GPR    (NUM_GPR),
            .IDLE_VALUE (IDLE_VALUE),
            .SRC_W      (SRC_W)
        ) uMux (
            .srcSel   (ctl.bus_src_sel[b*SRC_W +: SRC_W]),
            .gprFlat  (gprFlat),
            .pcLo     (pc[DATA_W-1:0]),
            .pcHi     (pc[ADDR_W-1:DATA_W]),
            .spVal    (sp),
            .dilVal   (dil),
            .constVal (ctl.const_in),
            .busVal   (busFlat[b*DATA_W +: DATA_W])
        );
    end

    // Load picks the base, then a lone inc/dec adjusts it (jump-then-advance).
    always_comb begin
        pcBase     = ctl.pc_load ? {pickBus(ctl.pc_hi_bus, busFlat), pickBus(ctl.pc_lo_bus, busFlat)} : pc;
        pcStep     = ctl.pc_inc ^ ctl.pc_dec;
        pcConflict = ctl.pc_inc & ctl.pc_dec;
        pcNext     = pcBase;
        if (ctl.pc_inc && !ctl.pc_dec) pcNext = pcBase + ADDR_W'(1);
        if (ctl.pc_dec && !ctl.pc_inc) pcNext = pcBase - ADDR_W'(1);
        pcCross    = (pcNext[ADDR_W-1:DATA_W] != pcBase[ADDR_W-1:DATA_W]);
    end

    always_comb begin
        spConflict = (ctl.sp_push & ctl.sp_pop) | (ctl.sp_push & ctl.sp_load) | (ctl.sp_pop & ctl.sp_load);
        spOp       = SP_HOLD;
        if (!spConflict) begin
            if (ctl.sp_push)     spOp = SP_PUSH;
            else if (ctl.sp_pop) spOp = SP_POP;
            else if (ctl.sp_load) spOp = SP_LOAD;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int g = 0; g < NUM_GPR; g++) gpr[g] <= '0;
            pc         <= RESET_PC;
            sp         <= SP_RESET;
            abl        <= '0;
            abh        <= '0;
            dor        <= '0;
            dil        <= '0;
            pageCross  <= 1'b0;
            illegalCmd <= '0;
        end else begin
            for (int g = 0; g < NUM_GPR; g++) begin
                if (ctl.gpr_load_en[g]) gpr[g] <= pickBus(ctl.gpr_load_bus[g*BUS_W +: BUS_W], busFlat);
            end
            pc <= pcNext;
            if (pcStep)     pageCross <= pcCross;
            if (pcConflict) illegalCmd[ILL_PC] <= 1'b1;
            case (spOp)
                SP_PUSH: sp <= sp - DATA_W'(1);
                SP_POP:  sp <= sp + DATA_W'(1);
                SP_LOAD: sp <= pickBus(ctl.sp_bus, busFlat);
                default: ;
            endcase
            if (spConflict)   illegalCmd[ILL_SP] <= 1'b1;
            if (ctl.abl_load) abl <= pickBus(ctl.abl_bus, busFlat);
            if (ctl.abh_load) abh <= pickBus(ctl.abh_bus, busFlat);
            if (ctl.dor_load) dor <= pickBus(ctl.dor_bus, busFlat);
            if (ctl.dil_load) dil <= ctl.ext_data_in;
        end
    end

    assign ctl.ext_data_out = dor;
    assign ctl.addr_out     = {abh, abl};
    assign ctl.pc_out       = pc;
    assign ctl.sp_out       = sp;
    assign ctl.page_cross   = pageCross;
    assign ctl.illegal_cmd  = illegalCmd;
    assign ctl.bus_mon      = busFlat;

endmodule

// File: tb/tb_dataflow_core_param.sv
// Directed bench for dataflow_core_param: stimulus pushes hand-computed
// expectations into a queue that a negedge monitor pops and compares.
module tb_dataflow_core_param;

    localparam int O_PC   = 0;
    localparam int O_SP   = 1;
    localparam int O_ADDR = 2;
    localparam int O_DOUT = 3;
    localparam int O_PAGE = 4;
    localparam int O_ILL  = 5;
    localparam int O_BUS0 = 6;
    localparam int O_BUS1 = 7;
    localparam int O_BUS2 = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [23:0] value;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dataflow_if #(.DATA_W(8), .NUM_GPR(3), .NUM_BUS(3)) dif ();

    dataflow_core_param #(
        .DATA_W(8), .NUM_GPR(3), .NUM_BUS(3),
        .RESET_PC(16'hFFFC), .SP_RESET(8'hFF), .IDLE_VALUE(8'hFF)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .ctl  (dif.slave)
    );

    function automatic logic [23:0] actualOf(input int sel);
        case (sel)
            O_PC:    return {8'h00, dif.pc_out};
            O_SP:    return {16'h0000, dif.sp_out};
            O_ADDR:  return {8'h00, dif.addr_out};
            O_DOUT:  return {16'h0000, dif.ext_data_out};
            O_PAGE:  return {23'h0, dif.page_cross};
            O_ILL:   return {22'h0, dif.illegal_cmd};
            O_BUS0:  return {16'h0000, dif.bus_mon[7:0]};
            O_BUS1:  return {16'h0000, dif.bus_mon[15:8]};
            O_BUS2:  return {16'h0000, dif.bus_mon[23:16]};
            default: return 24'hDEAD00;
        endcase
    endfunction

    // Monitor: every pending expectation is compared at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (actualOf(e.sel) !== e.value) begin
                    errors++;
                    $display("[TB] FAIL %s: actual %h required %h", e.name, actualOf(e.sel), e.value);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int sel, input logic [23:0] value);
        sb.push_back('{name, sel, value});
    endtask

    task automatic setSrc(input int b, input int code);
        dif.bus_src_sel[b*4 +: 4] = 4'(code);
    endtask

    task automatic setGprBus(input int g, input int idx);
        dif.gpr_load_bus[g*2 +: 2] = 2'(idx);
    endtask

    task automatic clearStrobes();
        dif.gpr_load_en = '0;
        dif.pc_inc = 1'b0;  dif.pc_dec = 1'b0;  dif.pc_load = 1'b0;
        dif.sp_push = 1'b0; dif.sp_pop = 1'b0;  dif.sp_load = 1'b0;
        dif.abl_load = 1'b0; dif.abh_load = 1'b0; dif.dor_load = 1'b0;
        dif.dil_load = 1'b0;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearStrobes();
    endtask

    task automatic syncNeg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        clearStrobes();
        dif.bus_src_sel = '0;
        dif.const_in = '0;
        dif.gpr_load_bus = '0;
        dif.pc_lo_bus = '0; dif.pc_hi_bus = '0; dif.sp_bus = '0;
        dif.abl_bus = '0; dif.abh_bus = '0; dif.dor_bus = '0;
        dif.ext_data_in = '0;
        syncNeg();
        syncNeg();
        nrst = 1'b1;

        checkOutput("rst_pc", O_PC, 24'hFFFC);
        checkOutput("rst_sp", O_SP, 24'hFF);
        checkOutput("rst_addr", O_ADDR, 24'h0000);
        checkOutput("rst_dout", O_DOUT, 24'h00);
        checkOutput("rst_ill", O_ILL, 24'h0);
        checkOutput("rst_page", O_PAGE, 24'h0);
        checkOutput("idle_bus0", O_BUS0, 24'hFF);
        syncNeg();

        // Transfer const -> GPR1 -> DOR, then address registers
        dif.const_in = 8'h5A; setSrc(0, 8); dif.gpr_load_en = 3'b010; setGprBus(1, 0);
        applyStimulus();
        syncNeg();
        setSrc(1, 2);
        checkOutput("bus1_gpr1", O_BUS1, 24'h5A);
        dif.dor_load = 1'b1; dif.dor_bus = 2'd1;
        applyStimulus();
        checkOutput("dor_xfer", O_DOUT, 24'h5A);
        syncNeg();
        dif.const_in = 8'h34; setSrc(2, 2);
        dif.abl_load = 1'b1; dif.abl_bus = 2'd0; dif.abh_load = 1'b1; dif.abh_bus = 2'd2;
        applyStimulus();
        checkOutput("addr_load", O_ADDR, 24'h5A34);
        syncNeg();

        // PC load / carry / borrow
        setSrc(0, 0); dif.const_in = 8'h12; setSrc(2, 8);
        dif.pc_load = 1'b1; dif.pc_lo_bus = 2'd0; dif.pc_hi_bus = 2'd2;
        applyStimulus();
        checkOutput("pc_load", O_PC, 24'h12FF);
        syncNeg();
        dif.pc_inc = 1'b1;
        applyStimulus();
        checkOutput("pc_carry", O_PC, 24'h1300);
        checkOutput("page_set", O_PAGE, 24'h1);
        syncNeg();
        dif.pc_inc = 1'b1;
        applyStimulus();
        checkOutput("pc_inc2", O_PC, 24'h1301);
        checkOutput("page_clr", O_PAGE, 24'h0);
        syncNeg();
        dif.const_in = 8'h00; dif.pc_load = 1'b1; dif.pc_lo_bus = 2'd2; dif.pc_hi_bus = 2'd2;
        applyStimulus();
        checkOutput("pc_zero", O_PC, 24'h0000);
        syncNeg();
        dif.pc_dec = 1'b1;
        applyStimulus();
        checkOutput("pc_wrap", O_PC, 24'hFFFF);
        checkOutput("page_borrow", O_PAGE, 24'h1);
        syncNeg();

        // SP wrap and conflict
        dif.sp_load = 1'b1; dif.sp_bus = 2'd2;
        applyStimulus();
        checkOutput("sp_load", O_SP, 24'h00);
        syncNeg();
        dif.sp_push = 1'b1;
        applyStimulus();
        checkOutput("sp_push_wrap", O_SP, 24'hFF);
        syncNeg();
        dif.sp_pop = 1'b1;
        applyStimulus();
        checkOutput("sp_pop_wrap", O_SP, 24'h00);
        syncNeg();
        dif.sp_push = 1'b1; dif.sp_pop = 1'b1;
        applyStimulus();
        checkOutput("sp_conflict", O_SP, 24'h00);
        checkOutput("ill_sp", O_ILL, 24'h2);
        syncNeg();
        dif.sp_pop = 1'b1;
        applyStimulus();
        checkOutput("sp_pop", O_SP, 24'h01);
        checkOutput("ill_sticky", O_ILL, 24'h2);
        syncNeg();

        // PC conflict and load-with-increment
        dif.pc_inc = 1'b1; dif.pc_dec = 1'b1;
        applyStimulus();
        checkOutput("pc_conflict", O_PC, 24'hFFFF);
        checkOutput("ill_both", O_ILL, 24'h3);
        checkOutput("page_hold", O_PAGE, 24'h1);
        syncNeg();
        dif.const_in = 8'hCD; setSrc(0, 8); dif.gpr_load_en = 3'b001; setGprBus(0, 0);
        applyStimulus();
        syncNeg();
        dif.const_in = 8'hAB; setSrc(2, 8); setSrc(0, 1);
        dif.pc_load = 1'b1; dif.pc_inc = 1'b1; dif.pc_lo_bus = 2'd0; dif.pc_hi_bus = 2'd2;
        applyStimulus();
        checkOutput("pc_load_inc", O_PC, 24'hABCE);
        checkOutput("page_load_inc", O_PAGE, 24'h0);
        syncNeg();
        setSrc(0, 4); setSrc(1, 5); setSrc(2, 6);
        checkOutput("bus_pcl", O_BUS0, 24'hCE);
        checkOutput("bus_pch", O_BUS1, 24'hAB);
        checkOutput("bus_sp", O_BUS2, 24'h01);
        syncNeg();

        // Idle sources, out-of-range bus index and source codes
        setSrc(0, 0); setSrc(1, 0); setSrc(2, 0);
        dif.gpr_load_en = 3'b001; setGprBus(0, 0);
        applyStimulus();
        setSrc(1, 1);
        checkOutput("gpr0_idle", O_BUS1, 24'hFF);
        syncNeg();
        dif.const_in = 8'h11; setSrc(0, 8); dif.gpr_load_en = 3'b100; setGprBus(2, 0);
        applyStimulus();
        setSrc(1, 3);
        checkOutput("gpr2_const", O_BUS1, 24'h11);
        syncNeg();
        dif.gpr_load_en = 3'b100; setGprBus(2, 3);
        applyStimulus();
        checkOutput("gpr2_badbus", O_BUS1, 24'hFF);
        syncNeg();
        setSrc(0, 9); setSrc(1, 8); setSrc(2, 15);
        checkOutput("src9_idle", O_BUS0, 24'hFF);
        checkOutput("src_const", O_BUS1, 24'h11);
        checkOutput("src15_idle", O_BUS2, 24'hFF);
        syncNeg();

        // Data-input latch
        dif.ext_data_in = 8'h3C; setSrc(0, 7);
        applyStimulus();
        checkOutput("dil_noload", O_BUS0, 24'h00);
        syncNeg();
        dif.dil_load = 1'b1;
        applyStimulus();
        checkOutput("dil_load", O_BUS0, 24'h3C);
        syncNeg();

        // Asynchronous reset mid-cycle with pc_inc high
        setSrc(1, 1);
        dif.pc_inc = 1'b1;
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("arst_pc", O_PC, 24'hFFFC);
        checkOutput("arst_sp", O_SP, 24'hFF);
        checkOutput("arst_addr", O_ADDR, 24'h0000);
        checkOutput("arst_ill", O_ILL, 24'h0);
        checkOutput("arst_dout", O_DOUT, 24'h00);
        checkOutput("arst_page", O_PAGE, 24'h0);
        checkOutput("arst_dil", O_BUS0, 24'h00);
        checkOutput("arst_gpr0", O_BUS1, 24'h00);
        syncNeg();
        clearStrobes();
        syncNeg();
        nrst = 1'b1;
        applyStimulus();
        checkOutput("release_pc", O_PC, 24'hFFFC);
        checkOutput("release_sp", O_SP, 24'hFF);
        syncNeg();

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: actual %0d pending required 0", sb.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
